// File: rtl/sim_pkg.sv
// Shared simulator-phase types and the event record carried by the monitor queue.
package sim_pkg;

    localparam int unsigned SIM_CYCLE_WIDTH = 32;

    typedef enum logic [1:0] {
        SIM_INVALID     = 2'b00,
        SIM_INITIALIZED = 2'b01,
        SIM_RUNNING     = 2'b10,
        SIM_COMPLETED   = 2'b11
    } sim_state_e;

    typedef struct packed {
        sim_state_e                 from;
        sim_state_e                 to;
        logic [SIM_CYCLE_WIDTH-1:0] cycle;
        logic                       illegal;
    } sim_event_t;

    // Only single forward steps INVALID->INITIALIZED->RUNNING->COMPLETED are legal.
    function automatic logic is_legal_step(sim_state_e from, sim_state_e to);
        return (from != SIM_COMPLETED) && (to == sim_state_e'(2'(from) + 2'd1));
    endfunction

endpackage

// File: rtl/sim_event_monitor_if.sv
// Event stream handshake between the monitor (master) and its consumer (slave).
interface sim_event_monitor_if #(
    parameter int unsigned CYCLE_WIDTH = 32
);
    logic                   evt_valid;
    logic                   evt_ready;
    logic [1:0]             evt_from;
    logic [1:0]             evt_to;
    logic [CYCLE_WIDTH-1:0] evt_cycle;
    logic                   evt_illegal;

    modport master (
        output evt_valid, evt_from, evt_to, evt_cycle, evt_illegal,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_from, evt_to, evt_cycle, evt_illegal,
        output evt_ready
    );
endinterface

// File: rtl/sim_event_fifo.sv
// First-word-fall-through event queue; head reads as zero while empty.
module sim_event_fifo
    import sim_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = sim_event_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   valid,
    output logic   full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && valid;
    // A full queue still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sim_event_monitor.sv
// Watches simulator phase changes, queues them as events and keeps run statistics.
// Define SIM_EVENT_MONITOR_CYCLE_CHECK_EN to compile in the cycle-continuity check.
module sim_event_monitor
    import sim_pkg::*;
#(
    parameter int unsigned CYCLE_WIDTH = SIM_CYCLE_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             sim_state,
    input  logic [CYCLE_WIDTH-1:0] sim_cycle,
    sim_event_monitor_if.master    evt,
    output logic [CYCLE_WIDTH-1:0] run_cycles,
    output logic                   completed,
    output logic                   proto_error,
    output logic                   cycle_error,
    output logic                   overflow,
    output logic [7:0]             drop_count
);
    sim_state_e cur_state;
    sim_state_e prev_state;
    sim_event_t new_event;
    sim_event_t head;
    logic       transition;
    logic       illegal;
    logic       q_valid;
    logic       q_full;
    logic       pop;
    logic       drop;

    assign cur_state  = sim_state_e'(sim_state);
    assign transition = (cur_state != prev_state);
    assign illegal    = transition && !is_legal_step(prev_state, cur_state);
    assign pop        = q_valid && evt.evt_ready;
    assign drop       = transition && q_full && !pop;

    assign new_event = '{from:    prev_state,
                         to:      cur_state,
                         cycle:   SIM_CYCLE_WIDTH'(sim_cycle),
                         illegal: illegal};

    sim_event_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (sim_event_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (transition),
        .push_data (new_event),
        .pop       (pop),
        .head      (head),
        .valid     (q_valid),
        .full      (q_full)
    );

    assign evt.evt_valid   = q_valid;
    assign evt.evt_from    = 2'(head.from);
    assign evt.evt_to      = 2'(head.to);
    assign evt.evt_cycle   = CYCLE_WIDTH'(head.cycle);
    assign evt.evt_illegal = head.illegal;

    // Phase history, run statistics and sticky protocol/overflow flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_state  <= SIM_INVALID;
            run_cycles  <= '0;
            completed   <= 1'b0;
            proto_error <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            prev_state <= cur_state;
            if (cur_state == SIM_RUNNING && !(&run_cycles))
                run_cycles <= run_cycles + CYCLE_WIDTH'(1);
            if (illegal) proto_error <= 1'b1;
            if (transition && !illegal && cur_state == SIM_COMPLETED) completed <= 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

`ifdef SIM_EVENT_MONITOR_CYCLE_CHECK_EN
    logic [CYCLE_WIDTH-1:0] prev_cycle;
    logic [CYCLE_WIDTH-1:0] expect_cycle;
    logic                   primed;

    assign expect_cycle = (&prev_cycle) ? prev_cycle : prev_cycle + CYCLE_WIDTH'(1);

    // The first edge after reset has no trustworthy predecessor, so it only primes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_cycle  <= '0;
            primed      <= 1'b0;
            cycle_error <= 1'b0;
        end else begin
            prev_cycle <= sim_cycle;
            primed     <= 1'b1;
            if (primed && sim_cycle != expect_cycle) cycle_error <= 1'b1;
        end
    end
`else
    assign cycle_error = 1'b0;
`endif

endmodule

// File: doc/sim_event_monitor.md
SIM_EVENT_MONITOR -- requirements
Module: sim_event_monitor

Interface
REQ-001 SHALL have parameter CYCLE_WIDTH, default 32: width of the observed cycle count.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event queue entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sim_state, input, 2 bits: simulator phase (00 INVALID, 01 INITIALIZED, 10 RUNNING, 11 COMPLETED).
REQ-006 SHALL have port sim_cycle, input, CYCLE_WIDTH bits: simulator cycle count; saturates at all-ones.
REQ-007 SHALL have port evt_valid, output, 1 bit: the head event is available.
REQ-008 SHALL have port evt_ready, input, 1 bit: the consumer accepts the head event.
REQ-009 SHALL have ports evt_from and evt_to, output, 2 bits each: the phases before and after the transition.
REQ-010 SHALL have port evt_cycle, output, CYCLE_WIDTH bits: sim_cycle sampled at the transition.
REQ-011 SHALL have port evt_illegal, output, 1 bit: the head transition is not a legal step.
REQ-012 SHALL have port run_cycles, output, CYCLE_WIDTH bits: the number of edges sampled in RUNNING.
REQ-013 SHALL have port completed, output, 1 bit: a legal RUNNING->COMPLETED transition has been seen.
REQ-014 SHALL have ports proto_error, cycle_error and overflow, output, 1 bit each: sticky error flags.
REQ-015 SHALL have port drop_count, output, 8 bits: the number of events lost to a full queue.

Function
REQ-016 SHALL sample sim_state and sim_cycle at every rising clk edge and hold them in prev_state and prev_cycle.
REQ-017 SHALL detect a transition at edge k when sim_state differs from prev_state (the value sampled at edge k-1).
REQ-018 SHALL build each event as {from=prev_state, to=sim_state, cycle=sim_cycle, illegal}, with all fields taken at edge k.
REQ-019 SHALL treat only 00->01, 01->10 and 10->11 as legal; every other change (skip, backward, exit from COMPLETED) sets illegal=1.
REQ-020 SHALL set proto_error at edge k when an illegal transition is detected; the flag then holds until reset.
REQ-021 SHALL push each event into the queue at edge k, so evt_valid is high in the cycle after edge k at the earliest.
REQ-022 SHALL pop the head event on every edge where evt_valid and evt_ready are both high; evt_* SHALL otherwise hold stable.
REQ-023 SHALL keep evt_valid independent of evt_ready; evt_valid SHALL be low only when the queue is empty.
REQ-024 SHALL accept a push into a full queue when a pop happens on the same edge; occupancy then stays at FIFO_DEPTH.
REQ-025 SHALL discard the event on a push into a full queue with no pop, set overflow, and increment drop_count.
REQ-026 SHALL saturate drop_count at 255.
REQ-027 SHALL accept a push and a pop on the same edge into a non-empty queue, leaving occupancy unchanged.
REQ-028 SHALL increment run_cycles at each edge where sim_state==10, saturating at all-ones.
REQ-029 SHALL set completed on a legal 10->11 transition; it then holds until reset.
REQ-030 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-031 SHALL, while reset is high, asynchronously clear prev_state, prev_cycle, the queue pointers and occupancy, run_cycles, drop_count and all flags.
REQ-032 SHALL show evt_valid=0, evt_from/evt_to/evt_cycle/evt_illegal=0, completed=0 and run_cycles=0 during reset.
REQ-033 SHALL discard any queued events when reset is asserted mid-operation; the first edge after release compares against prev_state=00.
REQ-034 SHALL skip the cycle-continuity check on the first edge after reset release.

Configuration
REQ-035 SHALL use macro SIM_EVENT_MONITOR_CYCLE_CHECK_EN to compile cycle checking in or out.
REQ-036 SHALL, with the macro defined, require sim_cycle==prev_cycle+1 when prev_cycle is not all-ones, and sim_cycle==all-ones when it is.
REQ-037 SHALL, with the macro defined, set sticky cycle_error on any edge that violates REQ-036.
REQ-038 SHALL, without the macro, tie cycle_error to 0 and include no comparison logic.

Structure
REQ-039 SHALL take these items from shared package sim_pkg: enum sim_state_e (SIM_INVALID, SIM_INITIALIZED, SIM_RUNNING, SIM_COMPLETED), struct sim_event_t {from, to, cycle, illegal}, and a function is_legal_step().
REQ-040 SHALL implement the queue as sub-module sim_event_fifo (parameterised by depth and by sim_event_t, with a first-word-fall-through head).

Verification
REQ-041 SHALL cover: state 00,01,10 for 100 edges,11 with cycle 0..n -> events 00->01, 01->10, 10->11 all legal; completed=1; run_cycles=100.
REQ-042 SHALL cover: state 01->11 -> evt_illegal=1 and proto_error=1, with evt_cycle equal to the sampled cycle.
REQ-043 SHALL cover: evt_ready=0 with 5 transitions and FIFO_DEPTH=4 -> 4 events queued, overflow=1, drop_count=1.
REQ-044 SHALL cover: a full queue with push and pop on the same edge -> no drop and occupancy 4.
REQ-045 SHALL cover, with the macro defined: cycle jump 7->9 -> cycle_error=1; cycle held at 0xFFFFFFFF -> no error.
REQ-046 SHALL cover: reset asserted with 3 events queued -> evt_valid=0 immediately, and a 00->01 step after release gives a single legal event.
